// File: rtl/idm_arbiter.sv
// Shares the single-ported unified instruction/data memory between the CPU and the loader/debug port.
// Each access is a fixed IDLE -> BUSY (MEM_LATENCY cycles) -> RESP sequence with a req/ack handshake on both sides.
module idm_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MEM_LATENCY  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_ack,
   input  logic                  ld_req,
   input  logic                  ld_we,
   input  logic [ADDR_WIDTH-1:0] ld_addr,
   input  logic [DATA_WIDTH-1:0] ld_wdata,
   output logic [DATA_WIDTH-1:0] ld_rdata,
   output logic                  ld_ack,
   output logic                  err,
   output logic                  owner,
   output logic                  busy,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-3:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] CNT_LOAD   = CW'(MEM_LATENCY - 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   logic [1:0]            state;
   logic [CW-1:0]         cnt;
   logic [SW-1:0]         starve_cnt;
   logic                  we_q;
   logic                  misaligned;
   logic                  grant_ld;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   // The CPU has priority unless the waiting loader has lost STARVE_LIMIT grants in a row.
   assign grant_ld  = ld_req && (!cpu_req || (starve_cnt == STARVE_MAX));
   assign sel_we    = grant_ld ? ld_we    : cpu_we;
   assign sel_addr  = grant_ld ? ld_addr  : cpu_addr;
   assign sel_wdata = grant_ld ? ld_wdata : cpu_wdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         starve_cnt <= '0;
         we_q       <= 1'b0;
         misaligned <= 1'b0;
         owner      <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         cpu_rdata  <= '0;
         ld_rdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu_req || ld_req) begin
                  state      <= BUSY;
                  owner      <= grant_ld;
                  we_q       <= sel_we;
                  mem_addr   <= sel_addr[ADDR_WIDTH-1:2];
                  mem_wdata  <= sel_wdata;
                  misaligned <= |sel_addr[1:0];
                  cnt        <= CNT_LOAD;
                  if (grant_ld || !ld_req)
                     starve_cnt <= '0;
                  else if (starve_cnt != STARVE_MAX)
                     starve_cnt <= starve_cnt + 1'b1;
               end
            end
            BUSY: begin
               if (cnt == '0) begin
                  state <= RESP;
                  if (!we_q && !misaligned) begin
                     if (owner)
                        ld_rdata  <= mem_rdata;
                     else
                        cpu_rdata <= mem_rdata;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // The memory strobe fires only in the first BUSY cycle, and never for a misaligned access.
   assign busy    = (state == BUSY) || (state == RESP);
   assign mem_en  = (state == BUSY) && (cnt == CNT_LOAD) && !misaligned;
   assign mem_we  = mem_en && we_q;
   assign cpu_ack = (state == RESP) && !owner;
   assign ld_ack  = (state == RESP) && owner;
   assign err     = (state == RESP) && misaligned;

endmodule

// File: tb/tb_idm_arbiter.sv
// Directed bench for idm_arbiter: three instances (MEM_LATENCY 1, 3, 2) each backed by a small word memory model.
module tb_idm_arbiter;

   logic        clk;
   logic        rst       [3];
   logic        cpu_req   [3];
   logic        cpu_we    [3];
   logic [31:0] cpu_addr  [3];
   logic [31:0] cpu_wdata [3];
   logic [31:0] cpu_rdata [3];
   logic        cpu_ack   [3];
   logic        ld_req    [3];
   logic        ld_we     [3];
   logic [31:0] ld_addr   [3];
   logic [31:0] ld_wdata  [3];
   logic [31:0] ld_rdata  [3];
   logic        ld_ack    [3];
   logic        err       [3];
   logic        owner     [3];
   logic        busy      [3];
   logic        mem_en    [3];
   logic        mem_we    [3];
   logic [29:0] mem_addr  [3];
   logic [31:0] mem_wdata [3];
   logic [31:0] mem_rdata [3];

   logic [31:0] mem [3][256];

   int testCount = 0;
   int failCount = 0;
   int cpuAckCount [3] = '{0, 0, 0};
   int memEnCount  [3] = '{0, 0, 0};
   int cycleNum = 0;

   int          resCycles;
   logic [31:0] resRdata;
   logic        resErr;
   logic        resOwner;
   logic        resFirstEn;
   logic        resFirstWe;
   logic [29:0] resFirstAddr;
   int          resAckCycle;

   idm_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) dut0 (
      .clk(clk), .reset(rst[0]),
      .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
      .cpu_rdata(cpu_rdata[0]), .cpu_ack(cpu_ack[0]),
      .ld_req(ld_req[0]), .ld_we(ld_we[0]), .ld_addr(ld_addr[0]), .ld_wdata(ld_wdata[0]),
      .ld_rdata(ld_rdata[0]), .ld_ack(ld_ack[0]),
      .err(err[0]), .owner(owner[0]), .busy(busy[0]),
      .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
      .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]));

   idm_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) dut1 (
      .clk(clk), .reset(rst[1]),
      .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
      .cpu_rdata(cpu_rdata[1]), .cpu_ack(cpu_ack[1]),
      .ld_req(ld_req[1]), .ld_we(ld_we[1]), .ld_addr(ld_addr[1]), .ld_wdata(ld_wdata[1]),
      .ld_rdata(ld_rdata[1]), .ld_ack(ld_ack[1]),
      .err(err[1]), .owner(owner[1]), .busy(busy[1]),
      .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
      .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]));

   idm_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(4)) dut2 (
      .clk(clk), .reset(rst[2]),
      .cpu_req(cpu_req[2]), .cpu_we(cpu_we[2]), .cpu_addr(cpu_addr[2]), .cpu_wdata(cpu_wdata[2]),
      .cpu_rdata(cpu_rdata[2]), .cpu_ack(cpu_ack[2]),
      .ld_req(ld_req[2]), .ld_we(ld_we[2]), .ld_addr(ld_addr[2]), .ld_wdata(ld_wdata[2]),
      .ld_rdata(ld_rdata[2]), .ld_ack(ld_ack[2]),
      .err(err[2]), .owner(owner[2]), .busy(busy[2]),
      .mem_en(mem_en[2]), .mem_we(mem_we[2]), .mem_addr(mem_addr[2]),
      .mem_wdata(mem_wdata[2]), .mem_rdata(mem_rdata[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: the address is held through BUSY, so a combinational read is valid by the capture edge.
   always @(posedge clk) begin
      cycleNum <= cycleNum + 1;
      for (int d = 0; d < 3; d++)
         if (mem_en[d] && mem_we[d])
            mem[d][mem_addr[d][7:0]] <= mem_wdata[d];
   end

   assign mem_rdata[0] = mem[0][mem_addr[0][7:0]];
   assign mem_rdata[1] = mem[1][mem_addr[1][7:0]];
   assign mem_rdata[2] = mem[2][mem_addr[2][7:0]];

   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (cpu_ack[d]) cpuAckCount[d] <= cpuAckCount[d] + 1;
         if (mem_en[d])  memEnCount[d]  <= memEnCount[d] + 1;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Runs one complete handshake on instance d; req starts in a fresh cycle and drops in the ack cycle.
   task automatic applyStimulus(input int d, input bit isLd, input bit we,
                                input logic [31:0] addr, input logic [31:0] wdata);
      bit done;
      tick;
      if (isLd) begin
         ld_req[d] = 1'b1; ld_we[d] = we; ld_addr[d] = addr; ld_wdata[d] = wdata;
      end else begin
         cpu_req[d] = 1'b1; cpu_we[d] = we; cpu_addr[d] = addr; cpu_wdata[d] = wdata;
      end
      resCycles = 1;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         tick;
         resCycles++;
         if (i == 0) begin
            resFirstEn = mem_en[d]; resFirstWe = mem_we[d]; resFirstAddr = mem_addr[d];
         end
         if (isLd ? ld_ack[d] : cpu_ack[d]) begin
            done        = 1'b1;
            resRdata    = isLd ? ld_rdata[d] : cpu_rdata[d];
            resErr      = err[d];
            resOwner    = owner[d];
            resAckCycle = cycleNum;
            if (isLd) ld_req[d] = 1'b0;
            else      cpu_req[d] = 1'b0;
         end
      end
      checkOutput("ack_within_bound", {31'd0, done}, 32'd1);
      ld_req[d]  = 1'b0;
      cpu_req[d] = 1'b0;
   endtask

   initial begin
      int grants [10];
      int n;
      int ackSnap;
      int enSnap;
      int firstAck;

      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b1;
         cpu_req[d] = 1'b0; cpu_we[d] = 1'b0; cpu_addr[d] = '0; cpu_wdata[d] = '0;
         ld_req[d]  = 1'b0; ld_we[d]  = 1'b0; ld_addr[d]  = '0; ld_wdata[d]  = '0;
      end
      tick;
      tick;
      checkOutput("reset_busy",      {31'd0, busy[0]},    32'd0);
      checkOutput("reset_acks",      {30'd0, cpu_ack[0], ld_ack[0]}, 32'd0);
      checkOutput("reset_err_owner", {30'd0, err[0], owner[0]},     32'd0);
      checkOutput("reset_mem_en_we", {30'd0, mem_en[0], mem_we[0]}, 32'd0);
      checkOutput("reset_mem_addr",  {2'd0, mem_addr[0]}, 32'd0);
      checkOutput("reset_mem_wdata", mem_wdata[0], 32'd0);
      checkOutput("reset_rdata",     cpu_rdata[0] | ld_rdata[0], 32'd0);
      for (int d = 0; d < 3; d++) rst[d] = 1'b0;

      // Preload images through the loader port.
      applyStimulus(0, 1'b1, 1'b1, 32'd0, 32'h20100200);
      applyStimulus(1, 1'b1, 1'b1, 32'd0, 32'h20100200);
      applyStimulus(1, 1'b1, 1'b1, 32'd4, 32'hAAAA5555);
      applyStimulus(2, 1'b1, 1'b1, 32'd0, 32'h20100200);

      // Loader write 55 to byte 512 and read it back.
      ackSnap = cpuAckCount[0];
      applyStimulus(0, 1'b1, 1'b1, 32'd512, 32'd55);
      checkOutput("ldwr_first_mem_en",   {31'd0, resFirstEn}, 32'd1);
      checkOutput("ldwr_first_mem_we",   {31'd0, resFirstWe}, 32'd1);
      checkOutput("ldwr_first_mem_addr", {2'd0, resFirstAddr}, 32'd128);
      checkOutput("ldwr_latency",        resCycles, 32'd3);
      checkOutput("ldwr_owner",          {31'd0, resOwner}, 32'd1);
      applyStimulus(0, 1'b1, 1'b0, 32'd512, 32'd0);
      checkOutput("ldrd_rdata",   resRdata, 32'd55);
      checkOutput("ldrd_latency", resCycles, 32'd3);
      checkOutput("ld_no_cpu_ack", cpuAckCount[0], ackSnap);

      // CPU read of word 0.
      applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0);
      checkOutput("cpurd_rdata", resRdata, 32'h20100200);
      checkOutput("cpurd_owner", {31'd0, resOwner}, 32'd0);
      checkOutput("cpurd_err",   {31'd0, resErr}, 32'd0);
      checkOutput("cpurd_ld_rdata_kept", ld_rdata[0], 32'd55);

      // Both requesters continuously active: loader wins every fifth grant.
      tick;
      cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 32'd0;
      ld_req[0]  = 1'b1; ld_we[0]  = 1'b0; ld_addr[0]  = 32'd512;
      n = 0;
      for (int i = 0; i < 200 && n < 10; i++) begin
         tick;
         if (cpu_ack[0]) begin
            grants[n] = 0; n++; cpu_req[0] = 1'b0;
         end else if (!cpu_req[0]) begin
            cpu_req[0] = 1'b1;
         end
         if (ld_ack[0]) begin
            grants[n] = 1; n++; ld_req[0] = 1'b0;
            checkOutput("starve_cnt_cleared", {29'd0, dut0.starve_cnt}, 32'd0);
         end else if (!ld_req[0]) begin
            ld_req[0] = 1'b1;
         end
      end
      cpu_req[0] = 1'b0;
      ld_req[0]  = 1'b0;
      checkOutput("starve_grant_count", n, 32'd10);
      for (int i = 0; i < n; i++)
         checkOutput($sformatf("starve_grant_%0d", i), grants[i], (i % 5 == 4) ? 32'd1 : 32'd0);

      // Misaligned loader write leaves memory untouched and flags err with the ack.
      enSnap = memEnCount[0];
      applyStimulus(0, 1'b1, 1'b1, 32'd514, 32'd99);
      checkOutput("mis_err",      {31'd0, resErr}, 32'd1);
      checkOutput("mis_latency",  resCycles, 32'd3);
      checkOutput("mis_no_mem_en", memEnCount[0], enSnap);
      checkOutput("mis_mem_word", mem[0][128], 32'd55);
      checkOutput("mis_ld_rdata", ld_rdata[0], 32'd55);

      // Reset in the second BUSY cycle with MEM_LATENCY=3.
      applyStimulus(1, 1'b0, 1'b0, 32'd0, 32'd0);
      checkOutput("l3_read_rdata",   resRdata, 32'h20100200);
      checkOutput("l3_read_latency", resCycles, 32'd5);
      tick;
      cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[1] = 32'd4;
      tick;
      tick;
      checkOutput("abort_busy_before", {31'd0, busy[1]}, 32'd1);
      ackSnap = cpuAckCount[1];
      rst[1] = 1'b1;
      tick;
      rst[1] = 1'b0;
      cpu_req[1] = 1'b0;
      checkOutput("abort_busy",      {31'd0, busy[1]}, 32'd0);
      checkOutput("abort_acks",      {30'd0, cpu_ack[1], ld_ack[1]}, 32'd0);
      checkOutput("abort_mem_en",    {31'd0, mem_en[1]}, 32'd0);
      checkOutput("abort_mem_addr",  {2'd0, mem_addr[1]}, 32'd0);
      checkOutput("abort_cpu_rdata", cpu_rdata[1], 32'd0);
      for (int i = 0; i < 5; i++) tick;
      checkOutput("abort_no_ack", cpuAckCount[1], ackSnap);
      applyStimulus(1, 1'b0, 1'b0, 32'd4, 32'd0);
      checkOutput("fresh_rdata",   resRdata, 32'hAAAA5555);
      checkOutput("fresh_latency", resCycles, 32'd5);

      // Back-to-back CPU read then write with MEM_LATENCY=2.
      applyStimulus(2, 1'b0, 1'b0, 32'd0, 32'd0);
      firstAck = resAckCycle;
      checkOutput("l2_read_rdata", resRdata, 32'h20100200);
      applyStimulus(2, 1'b0, 1'b1, 32'd516, 32'd88);
      checkOutput("l2_ack_spacing", resAckCycle - firstAck, 32'd4);
      checkOutput("l2_mem_word",    mem[2][129], 32'd88);
      checkOutput("l2_rdata_kept",  cpu_rdata[2], 32'h20100200);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/idm_arbiter.md
# idm_arbiter

Two-port arbiter that shares the CPU_MultiCycle unified instruction/data memory (IDM) between the CPU and a loader/debug port. The loader fills programs and data arrays (e.g. the bubble-sort image at word 0 and the array at byte 512) and reads back results, replacing hierarchical memory pokes. It sits between both requesters and the single-ported IDM. Each access runs a fixed-latency sequence. Both requesters use a req/ack handshake.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte-address width of requester ports
- DATA_WIDTH, 32, word width
- MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata (≥1)
- STARVE_LIMIT, 4, consecutive CPU wins over a waiting loader before loader is forced (≥1)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_WIDTH  byte address
- cpu_wdata  in  DATA_WIDTH  write data
- cpu_rdata  out  DATA_WIDTH  read data, valid with cpu_ack, held until next cpu_ack
- cpu_ack  out  1  one-cycle completion pulse
- ld_req, ld_we, ld_addr, ld_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  loader equivalents
- ld_rdata  out  DATA_WIDTH; ld_ack  out  1  loader equivalents
- err  out  1  pulses with the ack of a misaligned request
- owner  out  1  0=CPU, 1=loader; owner of the current/last grant
- busy  out  1  high in BUSY and RESP
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH-2  word index (byte addr >> 2)
- mem_wdata  out  DATA_WIDTH
- mem_rdata  in  DATA_WIDTH

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: if any req is sampled high, grant, latch we/addr/wdata and owner, then go to BUSY. If there is no request, stay in IDLE.
- Arbitration when both request: CPU wins unless starve_cnt == STARVE_LIMIT, in which case the loader wins.
- starve_cnt is evaluated at each IDLE grant:
  - increment if CPU granted while ld_req high
  - clear if loader granted, or if ld_req low
  - saturate at STARVE_LIMIT
- Misaligned request (addr[1:0]≠0): granted normally. No memory access: mem_en and mem_we stay 0 for the whole transaction. rdata register is not updated. err pulses with the ack.
- BUSY:
  - lasts exactly MEM_LATENCY cycles; internal counter loads MEM_LATENCY-1 and decrements.
  - mem_en and mem_we (mem_we = latched we) are high only in the first BUSY cycle.
  - mem_addr and mem_wdata hold the latched values throughout BUSY.
  - on the last BUSY edge, a read captures mem_rdata into the owner's rdata register.
- RESP: the owner's ack is high for exactly one cycle, then the FSM returns to IDLE. A req still high during RESP is ignored. The next grant is evaluated in IDLE.
- A write ack leaves that port's rdata unchanged.
- The non-owner's ack, rdata and err are never disturbed.

## Timing
- Reset values (edge with reset=1):
  - state IDLE
  - all acks, err, mem_en, mem_we, busy, owner = 0
  - cpu_rdata, ld_rdata, mem_addr, mem_wdata = 0
  - starve_cnt = 0
- Reset mid-transaction: abort to IDLE. No ack is produced for the aborted access. A write whose mem_en edge has already occurred is not rolled back.
- Request sampled at edge E (IDLE) → BUSY at cycles E+1..E+MEM_LATENCY → ack high in cycle E+MEM_LATENCY+1.
- Total latency: MEM_LATENCY+2 cycles per access, including the IDLE cycle. This is the maximum throughput.
- Handshake rules:
  - requester holds req and payload stable until it sees ack
  - requester must deassert req in the ack cycle or earlier; reassert no sooner than the cycle after the ack
- Payload changes after grant are ignored because payload is latched.

## Test plan
- Loader writes 55 to byte 512, then reads it back, with MEM_LATENCY=1 → mem_addr=128 and mem_we=1 in the write's first BUSY cycle; ld_ack 3 cycles after req; readback ld_rdata=55; cpu_ack never asserted.
- CPU reads word 0 holding 0x20100200 while ld_req is idle → cpu_rdata=0x20100200 with cpu_ack; owner=0; err=0.
- CPU and loader request continuously, STARVE_LIMIT=4 → grant sequence CPU,CPU,CPU,CPU,LD, then repeats; starve_cnt returns to 0 after each LD grant.
- Loader write to byte 514 (misaligned) → ld_ack and err pulse together; mem_en stays 0 throughout; memory word 128 unchanged.
- Reset asserted in the second BUSY cycle with MEM_LATENCY=3 → next cycle state IDLE, all outputs at reset values; no ack for the aborted access; a fresh CPU read then completes in 5 cycles.
- MEM_LATENCY=2 CPU read followed immediately by a CPU write to byte 516 with value 88 → acks 4 cycles apart; memory word 129 = 88; cpu_rdata keeps the earlier read value.
